// File: rtl/fanout_bcast_sched.sv
// rtl/fanout_bcast_sched.sv - broadcast one captured driver word to a masked set of loads
// At most MAX_FANOUT loads are offered the word in any cycle.
module fanout_bcast_sched #(
  parameter int DATA_W     = 8,
  parameter int NUM_LOADS  = 5,
  parameter int MAX_FANOUT = 2,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [NUM_LOADS-1:0] in_mask,
  output logic [DATA_W-1:0]    out_data,
  output logic [NUM_LOADS-1:0] out_valid,
  input  logic [NUM_LOADS-1:0] out_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam int CW = $clog2(NUM_LOADS + 1) + 1;
  localparam logic [CW-1:0] MF = CW'(MAX_FANOUT);

  typedef enum logic {IDLE, BCAST} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [NUM_LOADS-1:0] pending;
  logic [NUM_LOADS-1:0] pending_nxt;
  logic [NUM_LOADS-1:0] window;
  logic [DATA_W-1:0]    data_q;
  logic [CW-1:0]        seen;
  logic                 accept;

  // Lowest-index set bits fill the window; since bits only clear, an offered
  // load stays in the window until it accepts.
  always_comb begin
    window = '0;
    seen   = '0;
    for (int i = 0; i < NUM_LOADS; i++) begin
      if (pending[i] && (seen < MF)) begin
        window[i] = 1'b1;
        seen      = seen + CW'(1);
      end
    end
  end

  assign pending_nxt = pending & ~(out_valid & out_ready);
  assign accept      = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (in_mask != '0)) state_nxt = BCAST;
      BCAST:   if (pending_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == BCAST);
    out_valid = (state == BCAST) ? window : '0;
    out_data  = data_q;
  end

  // An all-zero mask is captured like any word but leaves pending empty,
  // so the word is dropped without touching the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      data_q   <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q  <= in_data;
            pending <= in_mask;
          end
        end
        BCAST: begin
          pending <= pending_nxt;
          if (pending_nxt == '0) word_cnt <= word_cnt + CNT_W'(1);
        end
        default: pending <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fanout_bcast_sched.sv
// tb/tb_fanout_bcast_sched.sv - directed self-checking bench for fanout_bcast_sched
module tb_fanout_bcast_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_mask;
  logic [7:0] out_data;
  logic [4:0] out_valid;
  logic [4:0] out_ready;
  logic       busy;
  logic [3:0] word_cnt;

  int checks   = 0;
  int failures = 0;

  fanout_bcast_sched #(
    .DATA_W(8), .NUM_LOADS(5), .MAX_FANOUT(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_mask   = 5'b00000;
    out_ready = 5'b00000;
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);

    // Test 1: full mask, all ready
    in_valid = 1'b1; in_data = 8'hA5; in_mask = 5'b11111; out_ready = 5'b11111;
    tick();
    in_valid = 1'b0;
    chk("t1_c1_valid", 32'(out_valid), 32'h03);
    chk("t1_c1_ready", 32'(in_ready), 32'd0);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    chk("t1_c1_data", 32'(out_data), 32'hA5);
    tick();
    chk("t1_c2_valid", 32'(out_valid), 32'h0C);
    tick();
    chk("t1_c3_valid", 32'(out_valid), 32'h10);
    tick();
    chk("t1_c4_ready", 32'(in_ready), 32'd1);
    chk("t1_c4_valid", 32'(out_valid), 32'd0);
    chk("t1_cnt", 32'(word_cnt), 32'd1);

    // Test 2: load1 stalls 4 cycles; in_data/in_mask change mid-delivery
    in_valid = 1'b1; in_data = 8'hA5; in_mask = 5'b10110; out_ready = 5'b11101;
    tick();
    in_valid = 1'b0; in_data = 8'hFF; in_mask = 5'b11111;
    chk("t2_c1_valid", 32'(out_valid), 32'h06);
    tick();
    chk("t2_c2_valid", 32'(out_valid), 32'h12);
    chk("t2_c2_data", 32'(out_data), 32'hA5);
    tick();
    chk("t2_c3_valid", 32'(out_valid), 32'h02);
    tick();
    chk("t2_c4_valid", 32'(out_valid), 32'h02);
    chk("t2_c4_data", 32'(out_data), 32'hA5);
    out_ready = 5'b11111;
    tick();
    chk("t2_done_ready", 32'(in_ready), 32'd1);
    chk("t2_done_valid", 32'(out_valid), 32'd0);
    chk("t2_cnt", 32'(word_cnt), 32'd2);

    // Test 3: empty mask is discarded
    in_valid = 1'b1; in_data = 8'h3C; in_mask = 5'b00000;
    tick();
    in_valid = 1'b0;
    chk("t3_ready", 32'(in_ready), 32'd1);
    chk("t3_valid", 32'(out_valid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    tick();
    chk("t3_cnt", 32'(word_cnt), 32'd2);

    // Test 4: reset with pending=11000
    in_valid = 1'b1; in_data = 8'h5A; in_mask = 5'b11011; out_ready = 5'b11111;
    tick();
    in_valid = 1'b0;
    chk("t4_c1_valid", 32'(out_valid), 32'h03);
    tick();
    chk("t4_c2_valid", 32'(out_valid), 32'h18);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_rst_valid", 32'(out_valid), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_ready", 32'(in_ready), 32'd1);
    chk("t4_rst_cnt", 32'(word_cnt), 32'd0);
    in_valid = 1'b1; in_data = 8'h77; in_mask = 5'b00101;
    tick();
    in_valid = 1'b0;
    chk("t4_next_valid", 32'(out_valid), 32'h05);
    chk("t4_next_data", 32'(out_data), 32'h77);
    tick();
    chk("t4_next_ready", 32'(in_ready), 32'd1);
    chk("t4_next_cnt", 32'(word_cnt), 32'd1);

    // Test 5: back-to-back single-load words with in_valid held
    in_valid = 1'b1; in_mask = 5'b00001; out_ready = 5'b11111;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'h10 + k);
      tick();
      in_data = 8'hEE;
      chk("t5_bcast_ready", 32'(in_ready), 32'd0);
      chk("t5_bcast_valid", 32'(out_valid), 32'h01);
      chk("t5_bcast_data", 32'(out_data), 32'(8'h10 + k));
      tick();
      chk("t5_idle_ready", 32'(in_ready), 32'd1);
      chk("t5_idle_valid", 32'(out_valid), 32'd0);
      chk("t5_cnt", 32'(word_cnt), 32'(2 + k));
    end
    in_valid = 1'b0;

    // Test 6: 4-bit counter wraps after 16 words
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_mask = 5'b00001; in_data = 8'h42;
    for (int k = 1; k <= 17; k++) begin
      tick();
      tick();
      if (k == 15) chk("t6_cnt15", 32'(word_cnt), 32'd15);
      if (k == 16) chk("t6_cnt_wrap", 32'(word_cnt), 32'd0);
    end
    in_valid = 1'b0;
    chk("t6_cnt_end", 32'(word_cnt), 32'd1);
    chk("t6_idle", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
